// File: rtl/interrupt_spr.sv
// Interrupt cause masking, priority encoding and special-purpose register file.
// Latency: mca/jisr/il are combinational; register updates take effect on the next clk edge.
// Backpressure: none; jisr pre-empts eret, which pre-empts spr_we, and losers are dropped.
module interrupt_spr (
    input  logic        clk,
    input  logic        rst,
    input  logic [22:0] ca,
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic [31:0] ea,
    input  logic        rpt,
    input  logic        spr_we,
    input  logic [2:0]  spr_addr,
    input  logic [31:0] spr_wdata,
    input  logic        eret,
    output logic [31:0] sr_out,
    output logic [31:0] esr_out,
    output logic [31:0] eca_out,
    output logic [31:0] epc_out,
    output logic [31:0] edata_out,
    output logic [31:0] pto,
    output logic [31:0] ptl,
    output logic        mode_out,
    output logic [22:0] mca,
    output logic        jisr,
    output logic [4:0]  il
);

    logic [31:0] r_sr;
    logic [31:0] r_esr;
    logic [31:0] r_eca;
    logic [31:0] r_epc;
    logic [31:0] r_edata;
    logic [31:0] r_pto;
    logic [31:0] r_ptl;
    logic        r_mode;

    logic [22:0] w_mca;
    logic        w_jisr;
    logic [4:0]  w_il;

    // Causes 0..5 are never masked; external/overflow causes are gated by the current sr bits.
    always_comb begin
        w_mca = {ca[22:6] & r_sr[22:6], ca[5:0]};
    end

    assign w_jisr = |w_mca;

    // Lowest set bit wins; scanning downwards leaves the lowest index as the final assignment.
    always_comb begin
        w_il = 5'd0;
        for (int i = 22; i >= 0; i--) begin
            if (w_mca[i]) begin
                w_il = 5'(i);
            end
        end
    end

    // Register file update: interrupt entry, then exception return, then software write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr    <= 32'd0;
            r_esr   <= 32'd0;
            r_eca   <= 32'd0;
            r_epc   <= 32'd0;
            r_edata <= 32'd0;
            r_pto   <= 32'd0;
            r_ptl   <= 32'd0;
            r_mode  <= 1'b0;
        end else if (w_jisr) begin
            r_esr   <= r_sr;
            r_sr    <= 32'd0;
            r_eca   <= {9'd0, w_mca};
            r_epc   <= rpt ? pc : next_pc;
            r_edata <= ea;
            r_mode  <= 1'b0;
        end else if (eret) begin
            r_sr   <= r_esr;
            r_mode <= 1'b1;
        end else if (spr_we) begin
            case (spr_addr)
                3'd0: r_sr    <= spr_wdata;
                3'd1: r_esr   <= spr_wdata;
                3'd2: r_eca   <= spr_wdata;
                3'd3: r_epc   <= spr_wdata;
                3'd4: r_edata <= spr_wdata;
                3'd5: r_pto   <= spr_wdata;
                3'd6: r_ptl   <= spr_wdata;
                3'd7: r_mode  <= spr_wdata[0];
                default: ;
            endcase
        end
    end

    assign sr_out    = r_sr;
    assign esr_out   = r_esr;
    assign eca_out   = r_eca;
    assign epc_out   = r_epc;
    assign edata_out = r_edata;
    assign pto       = r_pto;
    assign ptl       = r_ptl;
    assign mode_out  = r_mode;
    assign mca       = w_mca;
    assign jisr      = w_jisr;
    assign il        = w_il;

endmodule

// File: tb/tb_interrupt_spr.sv
// Directed bench for interrupt_spr with an expectation queue.
// Expectations are queued alongside stimulus and drained when outputs are sampled.
// Inputs change on negedge; outputs sampled #1 after a change or after posedge.
module tb_interrupt_spr;

    logic        clk;
    logic        rst;
    logic [22:0] ca;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] ea;
    logic        rpt;
    logic        spr_we;
    logic [2:0]  spr_addr;
    logic [31:0] spr_wdata;
    logic        eret;
    logic [31:0] sr_out;
    logic [31:0] esr_out;
    logic [31:0] eca_out;
    logic [31:0] epc_out;
    logic [31:0] edata_out;
    logic [31:0] pto;
    logic [31:0] ptl;
    logic        mode_out;
    logic [22:0] mca;
    logic        jisr;
    logic [4:0]  il;

    interrupt_spr dut (
        .clk       (clk),
        .rst       (rst),
        .ca        (ca),
        .pc        (pc),
        .next_pc   (next_pc),
        .ea        (ea),
        .rpt       (rpt),
        .spr_we    (spr_we),
        .spr_addr  (spr_addr),
        .spr_wdata (spr_wdata),
        .eret      (eret),
        .sr_out    (sr_out),
        .esr_out   (esr_out),
        .eca_out   (eca_out),
        .epc_out   (epc_out),
        .edata_out (edata_out),
        .pto       (pto),
        .ptl       (ptl),
        .mode_out  (mode_out),
        .mca       (mca),
        .jisr      (jisr),
        .il        (il)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        S_SR, S_ESR, S_ECA, S_EPC, S_EDATA, S_PTO, S_PTL, S_MODE, S_MCA, S_JISR, S_IL
    } sel_t;

    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t queue_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(sel_t sel);
        case (sel)
            S_SR:    return sr_out;
            S_ESR:   return esr_out;
            S_ECA:   return eca_out;
            S_EPC:   return epc_out;
            S_EDATA: return edata_out;
            S_PTO:   return pto;
            S_PTL:   return ptl;
            S_MODE:  return {31'd0, mode_out};
            S_MCA:   return {9'd0, mca};
            S_JISR:  return {31'd0, jisr};
            S_IL:    return {27'd0, il};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_t sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        queue_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (queue_q.size() > 0) begin
            e = queue_q.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        spr_we = 1'b0;
        eret   = 1'b0;
        ca     = 23'd0;
    endtask

    task automatic spr_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        ca        = 23'd0;
        eret      = 1'b0;
        spr_we    = 1'b1;
        spr_addr  = a;
        spr_wdata = d;
        @(posedge clk);
        #1;
        spr_we = 1'b0;
    endtask

    task automatic expect_all_zero(input string tag);
        expect_val({tag, "_sr"},    S_SR,    32'd0);
        expect_val({tag, "_esr"},   S_ESR,   32'd0);
        expect_val({tag, "_eca"},   S_ECA,   32'd0);
        expect_val({tag, "_epc"},   S_EPC,   32'd0);
        expect_val({tag, "_edata"}, S_EDATA, 32'd0);
        expect_val({tag, "_pto"},   S_PTO,   32'd0);
        expect_val({tag, "_ptl"},   S_PTL,   32'd0);
        expect_val({tag, "_mode"},  S_MODE,  32'd0);
        expect_val({tag, "_mca"},   S_MCA,   32'd0);
        expect_val({tag, "_jisr"},  S_JISR,  32'd0);
        expect_val({tag, "_il"},    S_IL,    32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        ca        = 23'd0;
        pc        = 32'd0;
        next_pc   = 32'd0;
        ea        = 32'd0;
        rpt       = 1'b0;
        spr_we    = 1'b0;
        spr_addr  = 3'd0;
        spr_wdata = 32'd0;
        eret      = 1'b0;

        // Reset state
        #2;
        expect_all_zero("reset");
        drain();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // System call, continue after instruction
        @(negedge clk);
        ca = 23'h000020; pc = 32'h100; next_pc = 32'h104; rpt = 1'b0; ea = 32'h55;
        #1;
        expect_val("sysc_jisr", S_JISR, 32'd1);
        expect_val("sysc_il",   S_IL,   32'd5);
        expect_val("sysc_mca",  S_MCA,  32'h20);
        drain();
        @(posedge clk); #1;
        expect_val("sysc_epc",   S_EPC,   32'h104);
        expect_val("sysc_eca",   S_ECA,   32'h20);
        expect_val("sysc_mode",  S_MODE,  32'd0);
        expect_val("sysc_sr",    S_SR,    32'd0);
        expect_val("sysc_edata", S_EDATA, 32'h55);
        drain();
        @(negedge clk); idle_inputs();

        // Masked external cause does nothing
        spr_write(3'd0, 32'h0);
        @(negedge clk);
        ca = 23'h000080;
        #1;
        expect_val("mask_mca",  S_MCA,  32'd0);
        expect_val("mask_jisr", S_JISR, 32'd0);
        expect_val("mask_il",   S_IL,   32'd0);
        drain();
        @(posedge clk); #1;
        expect_val("mask_epc_hold", S_EPC, 32'h104);
        expect_val("mask_eca_hold", S_ECA, 32'h20);
        drain();

        // Unmask bit 7 while the cause is pending: write lands, interrupt next cycle
        @(negedge clk);
        spr_we = 1'b1; spr_addr = 3'd0; spr_wdata = 32'h80;
        @(posedge clk); #1;
        spr_we = 1'b0;
        expect_val("unmask_sr",   S_SR,   32'h80);
        expect_val("unmask_jisr", S_JISR, 32'd1);
        expect_val("unmask_il",   S_IL,   32'd7);
        drain();
        @(negedge clk); idle_inputs();

        // Two non-maskable causes, restart instruction
        @(negedge clk);
        ca = 23'h00000C; rpt = 1'b1; pc = 32'h200; next_pc = 32'h204; ea = 32'h1233;
        #1;
        expect_val("malpff_il", S_IL, 32'd2);
        drain();
        @(posedge clk); #1;
        expect_val("malpff_epc",   S_EPC,   32'h200);
        expect_val("malpff_edata", S_EDATA, 32'h1233);
        expect_val("malpff_eca",   S_ECA,   32'hC);
        expect_val("malpff_esr",   S_ESR,   32'h80);
        expect_val("malpff_sr",    S_SR,    32'd0);
        drain();
        @(negedge clk); idle_inputs();

        // Page table registers via software write
        spr_write(3'd5, 32'hDEAD0000);
        spr_write(3'd6, 32'h10);
        expect_val("pto_wr", S_PTO, 32'hDEAD0000);
        expect_val("ptl_wr", S_PTL, 32'h10);
        drain();

        // Exception return
        spr_write(3'd1, 32'hFF00);
        @(negedge clk);
        eret = 1'b1;
        @(posedge clk); #1;
        eret = 1'b0;
        expect_val("eret_sr",   S_SR,   32'hFF00);
        expect_val("eret_mode", S_MODE, 32'd1);
        expect_val("eret_epc",  S_EPC,  32'h200);
        drain();

        // jisr beats eret and spr_we together; page table registers untouched
        @(negedge clk);
        ca = 23'h000002; eret = 1'b1; spr_we = 1'b1; spr_addr = 3'd5; spr_wdata = 32'h1234;
        #1;
        expect_val("prio_il", S_IL, 32'd1);
        drain();
        @(posedge clk); #1;
        expect_val("prio_sr",   S_SR,   32'd0);
        expect_val("prio_esr",  S_ESR,  32'hFF00);
        expect_val("prio_eca",  S_ECA,  32'h2);
        expect_val("prio_mode", S_MODE, 32'd0);
        expect_val("prio_pto",  S_PTO,  32'hDEAD0000);
        drain();
        @(negedge clk); idle_inputs();

        // eret beats spr_we
        @(negedge clk);
        eret = 1'b1; spr_we = 1'b1; spr_addr = 3'd0; spr_wdata = 32'h5;
        @(posedge clk); #1;
        expect_val("eret_we_sr", S_SR, 32'hFF00);
        drain();
        @(negedge clk); idle_inputs();

        // Highest external bit, and reset cause outranks an enabled external one
        spr_write(3'd0, 32'h00400040);
        @(negedge clk);
        ca = 23'h400000;
        #1;
        expect_val("bit22_il", S_IL, 32'd22);
        drain();
        ca = 23'h000041;
        #1;
        expect_val("bit0_il", S_IL, 32'd0);
        expect_val("bit0_mca", S_MCA, 32'h41);
        drain();
        ca = 23'h3FFF80;
        #1;
        expect_val("partmask_mca", S_MCA, 32'd0);
        drain();
        idle_inputs();

        // Mode write via address 7
        spr_write(3'd7, 32'h3);
        expect_val("mode_wr", S_MODE, 32'd1);
        drain();

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect_all_zero("arst");
        drain();

        // Writes ignored while reset held; cause still visible combinationally
        @(negedge clk);
        ca = 23'h000001; spr_we = 1'b1; spr_addr = 3'd5; spr_wdata = 32'hFFFF;
        #1;
        expect_val("rst_jisr", S_JISR, 32'd1);
        drain();
        @(posedge clk); #1;
        expect_val("rst_pto", S_PTO, 32'd0);
        expect_val("rst_eca", S_ECA, 32'd0);
        drain();
        @(negedge clk); idle_inputs();
        rst = 1'b0;

        // First edge after release updates normally
        spr_write(3'd6, 32'h77);
        expect_val("post_rst_ptl", S_PTL, 32'h77);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
